posit_normalize_es3: RTL and testbench

// - Pipelined posit encoder (es=3): packs a decoded value (sign, scale, fraction, zero, inf) plus guard/sticky bits

---
 rtl/posit_defines_es3.sv | 58 +++++
 rtl/posit_regime_build_es3.sv | 28 ++
 rtl/posit_normalize_es3.sv | 146 ++++++++++++++
 tb/tb_posit_normalize_es3.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_defines_es3.sv
// Shared definitions for the es=3 posit encoder: format widths, the decoded
// value that arrives from the arithmetic units, the per-stage pipeline
// payloads and the field-placement helper used by the shift/round stage.
package posit_defines_es3;

  localparam int NBITS   = 32;
  localparam int ES      = 3;
  localparam int FBITS   = 26;
  localparam int SCALE_W = 9;
  localparam int MAG_W   = NBITS - 1;       // magnitude bits below the sign
  localparam int RUN_W   = 6;               // regime width, 2..33
  localparam int TAIL_W  = ES + FBITS + 2;  // exponent, fraction, guard, sticky
  localparam int FIELD_W = 2 * NBITS;       // regime slot plus shifted tail
  localparam int DROP_W  = FIELD_W - MAG_W; // bits below the kept magnitude

  localparam logic signed [SCALE_W-1:0] SCALE_MAX = 9'sd240;

  localparam logic [NBITS-1:0] POSIT_MAXPOS = 32'h7FFF_FFFF;
  localparam logic [NBITS-1:0] POSIT_MINPOS = 32'h0000_0001;
  localparam logic [NBITS-1:0] POSIT_NAR    = 32'h8000_0000;

  // Decoded value as produced by the arithmetic units.
  typedef struct packed {
    logic                      sign;
    logic signed [SCALE_W-1:0] scale;
    logic [FBITS-1:0]          fraction;  // hidden bit excluded
    logic                      zero;
    logic                      inf;
  } posit_value_t;

  // Payload after clamp/regime.
  typedef struct packed {
    logic             sign;
    logic             zero;
    logic             inf;
    logic             sat;
    logic [MAG_W-1:0] sat_mag;
    logic [NBITS-1:0] regime;  // left-aligned regime bit string
    logic [RUN_W-1:0] rw;      // regime width including terminator
    logic [TAIL_W-1:0] tail;
  } s1_t;

  // Payload after shift/round.
  typedef struct packed {
    logic             sign;
    logic             zero;
    logic             inf;
    logic [MAG_W-1:0] mag;
  } s2_t;

  // Regime occupies the top of the field; the tail follows immediately after it.
  function automatic logic [FIELD_W-1:0] place_fields(input logic [NBITS-1:0]  regime,
                                                      input logic [RUN_W-1:0]  rw,
                                                      input logic [TAIL_W-1:0] tail);
    return {regime, {NBITS{1'b0}}} | ({tail, {(FIELD_W-TAIL_W){1'b0}}} >> rw);
  endfunction

endpackage

// File: rtl/posit_regime_build_es3.sv
// Regime bit-string generator: k >= 0 gives (k+1) ones then a zero,
// k < 0 gives (-k) zeros then a one. The string is left-aligned in NBITS
// and width counts the terminating bit.
module posit_regime_build_es3
  import posit_defines_es3::*;
(
  input  logic signed [RUN_W-1:0] k,
  output logic [NBITS-1:0]        regime,
  output logic [RUN_W-1:0]        width
);

  logic [RUN_W-1:0] run;

  // Run length and left-aligned regime pattern from the sign of k.
  // NOTE: every output of a combinational block is assigned on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    if (k[RUN_W-1]) begin
      run    = RUN_W'(-k);
      regime = {1'b1, {(NBITS-1){1'b0}}} >> run;
    end else begin
      run    = RUN_W'(k) + RUN_W'(1);
      regime = ~({NBITS{1'b1}} >> run);
    end
    width = run + RUN_W'(1);
  end

endmodule

// File: rtl/posit_normalize_es3.sv
// Three-stage posit (es=3) encoder with valid/ready on both sides.
//   S1: saturation detect, regime construction
//   S2: field placement, rounding, minpos/maxpos clamp
//   S3: two's-complement sign, zero/NaR specials
// Build option: define POSIT_NORM_RNE_EN for round-to-nearest-even;
// without it the dropped bits are truncated.
module posit_normalize_es3
  import posit_defines_es3::*;
#(
  parameter int PIPE_STAGES = 3
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  posit_value_t     in,
  input  logic             in_guard,
  input  logic             in_sticky,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out
);

  if (PIPE_STAGES != 3) begin : g_bad_stages
    $error("posit_normalize_es3: PIPE_STAGES must be 3");
  end

  logic v1, v2, v3;
  logic en1, en2, en3;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  logic [NBITS-1:0] out_d;

  // A stage may load when its own slot is empty or the next one is moving,
  // so bubbles collapse and full rate is sustained.
  assign en3       = out_ready | ~v3;
  assign en2       = en3 | ~v2;
  assign en1       = en2 | ~v1;
  assign in_ready  = rst_n & en1;
  assign out_valid = v3;

  // ---------------- S1: clamp / regime ----------------
  logic signed [SCALE_W-1:0] scale;
  logic signed [RUN_W-1:0]   k;
  logic [NBITS-1:0]          regime;
  logic [RUN_W-1:0]          rw;

  assign scale = $signed(in.scale);
  assign k     = RUN_W'(scale >>> ES);

  posit_regime_build_es3 u_regime (
    .k      (k),
    .regime (regime),
    .width  (rw)
  );

  // Collect S1 payload; saturated values carry their final magnitude.
  always_comb begin
    s1_d         = '0;
    s1_d.sign    = in.sign;
    s1_d.zero    = in.zero;
    s1_d.inf     = in.inf;
    s1_d.sat     = (scale > SCALE_MAX) || (scale < -SCALE_MAX);
    s1_d.sat_mag = (scale > SCALE_MAX) ? POSIT_MAXPOS[MAG_W-1:0] : POSIT_MINPOS[MAG_W-1:0];
    s1_d.regime  = regime;
    s1_d.rw      = rw;
    s1_d.tail    = {scale[ES-1:0], in.fraction, in_guard, in_sticky};
  end

  // ---------------- S2: shift / round ----------------
  logic [MAG_W-1:0] trunc;
  logic             round_up;
  logic [MAG_W:0]   sum;

`ifdef POSIT_NORM_RNE_EN
  logic [DROP_W-1:0] dropped;
  assign {trunc, dropped} = place_fields(s1_q.regime, s1_q.rw, s1_q.tail);
  assign round_up = dropped[DROP_W-1] & (trunc[0] | (|dropped[DROP_W-2:0]));
`else
  assign trunc    = MAG_W'(place_fields(s1_q.regime, s1_q.rw, s1_q.tail) >> DROP_W);
  assign round_up = 1'b0;
`endif

  assign sum = {1'b0, trunc} + {{MAG_W{1'b0}}, round_up};

  // Final magnitude: saturation wins, then carry clamp, then never-zero clamp.
  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.zero = s1_q.zero;
    s2_d.inf  = s1_q.inf;
    if (s1_q.sat)
      s2_d.mag = s1_q.sat_mag;
    else if (sum[MAG_W])
      s2_d.mag = POSIT_MAXPOS[MAG_W-1:0];
    else if (sum[MAG_W-1:0] == '0)
      s2_d.mag = POSIT_MINPOS[MAG_W-1:0];
    else
      s2_d.mag = sum[MAG_W-1:0];
  end

  // ---------------- S3: sign / special ----------------
  // NaR outranks zero; specials ignore everything else.
  always_comb begin
    out_d = {1'b0, s2_q.mag};
    if (s2_q.inf)
      out_d = POSIT_NAR;
    else if (s2_q.zero)
      out_d = '0;
    else if (s2_q.sign)
      out_d = -{1'b0, s2_q.mag};
  end

  // ---------------- registers ----------------
  // Stage valid bits advance when the downstream slot frees; reset flushes them.
  // NOTE: state uses non-blocking assignments so every stage samples the
  // pre-edge value of its predecessor, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (en1) v1 <= in_valid;
      if (en2) v2 <= v1;
      if (en3) v3 <= v2;
    end
  end

  // Payload registers load only with valid data.
  // NOTE: the payload is not reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (en1 && in_valid) s1_q <= s1_d;
    if (en2 && v1)       s2_q <= s2_d;
  end

  // Output register, cleared by reset and held while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n)
      out <= '0;
    else if (en3 && v2)
      out <= out_d;
  end

endmodule

// File: tb/tb_posit_normalize_es3.sv
// Self-checking bench for posit_normalize_es3: directed vectors, stall and
// mid-flight reset scenarios, then randomized traffic against a bit-string
// reference model with a scoreboard.
module tb_posit_normalize_es3;
  import posit_defines_es3::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  posit_value_t     in_val = '0;
  logic             in_guard = 1'b0;
  logic             in_sticky = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [NBITS-1:0] out_data;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb[$];

  posit_normalize_es3 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_val),
    .in_guard  (in_guard),
    .in_sticky (in_sticky),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic posit_value_t mk(input bit sign, input int scale,
                                      input logic [FBITS-1:0] frac,
                                      input bit zero, input bit inf);
    posit_value_t v;
    v.sign     = sign;
    v.scale    = 9'(scale);
    v.fraction = frac;
    v.zero     = zero;
    v.inf      = inf;
    return v;
  endfunction

  // Reference: spell the posit out bit by bit, then take the first 31 bits.
  function automatic logic [31:0] ref_posit(input posit_value_t v, input bit g, input bit s);
    int     scale;
    int     k;
    int     e;
    longint mag;
    bit     bits[$];
`ifdef POSIT_NORM_RNE_EN
    bit     rb;
    bit     st;
`endif
    if (v.inf)  return 32'h8000_0000;
    if (v.zero) return 32'h0000_0000;
    scale = int'($signed(v.scale));
    if (scale > 240) begin
      mag = 64'h7FFF_FFFF;
    end else if (scale < -240) begin
      mag = 1;
    end else begin
      k = (scale >= 0) ? scale / 8 : -((-scale + 7) / 8);
      e = scale - 8 * k;
      if (k >= 0) begin
        repeat (k + 1) bits.push_back(1'b1);
        bits.push_back(1'b0);
      end else begin
        repeat (-k) bits.push_back(1'b0);
        bits.push_back(1'b1);
      end
      for (int i = 2; i >= 0; i--) bits.push_back(e[i]);
      for (int i = FBITS - 1; i >= 0; i--) bits.push_back(v.fraction[i]);
      bits.push_back(g);
      bits.push_back(s);
      mag = 0;
      for (int i = 0; i < 31; i++) mag = (mag << 1) | longint'(bits[i]);
`ifdef POSIT_NORM_RNE_EN
      rb = bits[31];
      st = 1'b0;
      for (int i = 32; i < bits.size(); i++) st |= bits[i];
      if (rb && (mag[0] || st)) mag++;
      if (mag > 64'h7FFF_FFFF) mag = 64'h7FFF_FFFF;
`endif
      if (mag == 0) mag = 1;
    end
    return v.sign ? 32'(64'h1_0000_0000 - mag) : 32'(mag);
  endfunction

  function automatic posit_value_t rand_val();
    int bnd[4] = '{-241, -240, 240, 241};
    int sel    = int'($urandom_range(0, 15));
    int scale  = int'($urandom_range(0, 511)) - 256;
    if (sel == 0) scale = bnd[$urandom_range(0, 3)];
    return mk(1'($urandom()), scale, FBITS'($urandom()), sel == 1 || sel == 3, sel == 2 || sel == 3);
  endfunction

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  // Push one value through an empty pipeline and check the result.
  task automatic run_directed(input string tag, input posit_value_t v, input bit g,
                              input bit s, input logic [31:0] exp, input bit check_lat);
    int lat = 0;
    bit seen = 1'b0;
    next_drive();
    in_val    = v;
    in_guard  = g;
    in_sticky = s;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    next_drive();
    in_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat  = i;
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) check(tag, out_data, exp);
    if (check_lat) check("latency", 32'(lat), 32'd3);
  endtask

  initial begin
    posit_value_t sv[5];
    logic [31:0]  se[5];
    int           idx;
    int           cnt;
    bit           prev_stall;
    posit_value_t rv;

    // ---- reset state (input offered, must not be accepted) ----
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out", out_data, 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    next_drive();
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // ---- directed vectors ----
    run_directed("one",       mk(0, 0, 0, 0, 0), 0, 0, 32'h4000_0000, 1'b1);
    run_directed("neg_one",   mk(1, 0, 0, 0, 0), 0, 0, 32'hC000_0000, 1'b0);
    run_directed("scale_m1",  mk(0, -1, 0, 0, 0), 0, 0, 32'h3C00_0000, 1'b0);
    run_directed("zero",      mk(1, 17, 26'h155, 1, 0), 1, 1, 32'h0000_0000, 1'b0);
    run_directed("inf",       mk(0, 5, 0, 0, 1), 0, 0, 32'h8000_0000, 1'b0);
    run_directed("inf_zero",  mk(1, 5, 0, 1, 1), 1, 0, 32'h8000_0000, 1'b0);
    run_directed("sat_hi",    mk(0, 250, 0, 0, 0), 0, 0, 32'h7FFF_FFFF, 1'b0);
    run_directed("sat_lo",    mk(0, -250, 0, 0, 0), 0, 0, 32'h0000_0001, 1'b0);
    run_directed("edge_hi",   mk(0, 240, 0, 0, 0), 0, 0, 32'h7FFF_FFFF, 1'b0);
    run_directed("edge_lo",   mk(0, -240, 0, 0, 0), 0, 0, 32'h0000_0001, 1'b0);
    run_directed("neg_sat",   mk(1, 250, 0, 0, 0), 1, 1, 32'h8000_0001, 1'b0);
`ifdef POSIT_NORM_RNE_EN
    run_directed("rnd_carry", mk(0, 0, 26'h3FF_FFFF, 0, 0), 1, 0, 32'h4400_0000, 1'b0);
    run_directed("tie_even",  mk(0, 0, 0, 0, 0), 1, 0, 32'h4000_0000, 1'b0);
    run_directed("tie_stky",  mk(0, 0, 0, 0, 0), 1, 1, 32'h4000_0001, 1'b0);
`else
    run_directed("rnd_carry", mk(0, 0, 26'h3FF_FFFF, 0, 0), 1, 0, 32'h43FF_FFFF, 1'b0);
    run_directed("tie_even",  mk(0, 0, 0, 0, 0), 1, 0, 32'h4000_0000, 1'b0);
    run_directed("tie_stky",  mk(0, 0, 0, 0, 0), 1, 1, 32'h4000_0000, 1'b0);
`endif

    // ---- stall: 5 offered, 3 accepted, output frozen ----
    for (int i = 0; i < 5; i++) begin
      sv[i] = mk(1'($urandom()), int'($urandom_range(0, 400)) - 200, FBITS'($urandom()), 0, 0);
      se[i] = ref_posit(sv[i], 1'b0, 1'b0);
    end
    next_drive();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_guard  = 1'b0;
    in_sticky = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_val = sv[idx];
      @(negedge clk);
      if (in_ready) idx++;
      next_drive();
    end
    check("stall_accepted", 32'(idx), 32'd3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_hold", out_data, se[0]);
      next_drive();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("release_valid", 32'(out_valid), 32'd1);
      check("release_data", out_data, se[i]);
      next_drive();
    end
    @(negedge clk);
    check("release_empty", 32'(out_valid), 32'd0);

    // ---- reset with two values in flight ----
    next_drive();
    in_val   = mk(0, 3, 0, 0, 0);
    in_valid = 1'b1;
    @(negedge clk);
    next_drive();
    in_val = mk(1, -7, 0, 0, 0);
    @(negedge clk);
    next_drive();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    next_drive();
    @(negedge clk);
    check("rst_flush_valid", 32'(out_valid), 32'd0);
    next_drive();
    rst_n = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("no_stale", 32'(cnt), 32'd0);

    // ---- randomized traffic against the scoreboard ----
    prev_stall = 1'b0;
    for (int c = 0; c < 800; c++) begin
      next_drive();
      rv        = rand_val();
      in_val    = rv;
      in_guard  = 1'($urandom());
      in_sticky = 1'($urandom());
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (prev_stall) check("rand_hold_valid", 32'(out_valid), 32'd1);
      if (out_valid) begin
        check("rand_sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          check("rand_data", out_data, sb[0]);
          if (out_ready) void'(sb.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      if (in_valid && in_ready) sb.push_back(ref_posit(rv, in_guard, in_sticky));
    end

    // ---- drain ----
    next_drive();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (out_valid) begin
        check("drain_data", out_data, sb[0]);
        void'(sb.pop_front());
      end
      next_drive();
    end
    check("drain_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
